// File: rtl/demux32x2_reg.sv
// demux32x2_reg: registered 1:2 valid/ready stream demux, one output register per channel.
// Rev 1.0 -- define DEMUX_CNT_EN to add the cnt0/cnt1 per-channel transfer counters.
`default_nettype none

module demux32x2_reg #(
  parameter int WIDTH = 32
`ifdef DEMUX_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_CNT_EN
  , output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
`endif
);

  logic free0;
  logic free1;
  logic load0;
  logic load1;

  // A channel can take a word when empty or when its current word leaves this edge.
  assign free0    = ~out0_valid | out0_ready;
  assign free1    = ~out1_valid | out1_ready;
  assign in_ready = rst_n & (in_select ? free1 : free0);
  assign load0    = in_valid & in_ready & ~in_select;
  assign load1    = in_valid & in_ready &  in_select;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0_data  <= '0;
      out0_valid <= 1'b0;
      out1_data  <= '0;
      out1_valid <= 1'b0;
    end else begin
      if (load0) begin
        out0_data  <= in_data;
        out0_valid <= 1'b1;
      end else if (out0_ready) begin
        out0_valid <= 1'b0;
      end
      if (load1) begin
        out1_data  <= in_data;
        out1_valid <= 1'b1;
      end else if (out1_ready) begin
        out1_valid <= 1'b0;
      end
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0 <= cnt0 + 1'b1;
      if (out1_valid && out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux32x2_reg.sv
// tb_demux32x2_reg: scoreboard bench for demux32x2_reg with a per-channel queue reference model.
`default_nettype none

module tb_demux32x2_reg;

`ifdef DEMUX_CNT_EN
  localparam int CW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_select = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready = 1'b1;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready = 1'b1;
`ifdef DEMUX_CNT_EN
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
`endif

  demux32x2_reg #(
    .WIDTH(32)
`ifdef DEMUX_CNT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_select(in_select), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready)
`ifdef DEMUX_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: words accepted but not yet delivered, per channel, in order.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int n0 = 0;
  int n1 = 0;
  bit rst_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: 2 time units after each edge, compare outputs against the queue heads.
  always @(posedge clk) begin
    #2;
    if (rst_pending) begin
      chk("reset_out0_data", {32'd0, out0_data}, 64'd0);
      chk("reset_out1_data", {32'd0, out1_data}, 64'd0);
      rst_pending = 1'b0;
    end
`ifdef DEMUX_CNT_EN
    chk("cnt0", {60'd0, cnt0}, 64'(n0 % (1 << CW)));
    chk("cnt1", {60'd0, cnt1}, 64'(n1 % (1 << CW)));
`endif
    if (q0.size() == 0) begin
      chk("out0_valid", {63'd0, out0_valid}, 64'd0);
    end else begin
      chk("out0_valid", {63'd0, out0_valid}, 64'd1);
      chk("out0_data", {32'd0, out0_data}, {32'd0, q0[0]});
      if (out0_ready) begin
        void'(q0.pop_front());
        n0++;
      end
    end
    if (q1.size() == 0) begin
      chk("out1_valid", {63'd0, out1_valid}, 64'd0);
    end else begin
      chk("out1_valid", {63'd0, out1_valid}, 64'd1);
      chk("out1_data", {32'd0, out1_data}, {32'd0, q1[0]});
      if (out1_ready) begin
        void'(q1.pop_front());
        n1++;
      end
    end
  end

  // Scoreboard input side: predict in_ready and push accepted words (after the monitor's pops).
  always @(posedge clk) begin
    #7;
    if (!rst_n) begin
      chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
      q0.delete();
      q1.delete();
      n0 = 0;
      n1 = 0;
      rst_pending = 1'b1;
    end else begin
      logic exp_rdy;
      exp_rdy = in_select ? (q1.size() == 0) : (q0.size() == 0);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (in_valid && exp_rdy) begin
        if (in_select) q1.push_back(in_data);
        else           q0.push_back(in_data);
      end
    end
  end

  task automatic drive(input logic rst_v, input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    rst_n = rst_v; in_valid = v; in_select = s; in_data = d;
    out0_ready = r0; out1_ready = r1;
  endtask

  initial begin
    // Reset held 2 cycles with in_valid high.
    rst_n = 1'b0; in_valid = 1'b1; in_select = 1'b0; in_data = 32'hFFFF_FFFF;
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Steer one word to each channel.
    drive(1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h5A5A_0002, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Backpressure on channel 0: second word waits until the first drains.
    drive(1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 32'h2, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h2, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Channel 0 stalled full while channel 1 still accepts.
    drive(1'b1, 1'b1, 1'b0, 32'h3, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h7, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Streaming, alternating channels.
    for (int i = 0; i < 100; i++)
      drive(1'b1, 1'b1, 1'(i), 32'h1000_0000 + 32'(i), 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Mid-operation reset while channel 1 holds an undelivered word.
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // 17 transfers on channel 0 (counter wrap when counters are built in).
    for (int i = 0; i < 17; i++)
      drive(1'b1, 1'b1, 1'b0, 32'h2000_0000 + 32'(i), 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 600; i++)
      drive(($urandom % 80) != 0, ($urandom % 4) != 0, 1'($urandom), 32'($urandom),
            ($urandom % 3) != 0, ($urandom % 2) != 0);

    repeat (4) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    #4;
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
